// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the fetch PC sequencer: the sequencer state
//   encoding, the instruction-alignment mask, the sequential PC step and the
//   default reset PC. It also provides a helper that classifies a redirect
//   target as misaligned.
// ---------------------------------------------------------------------------
package fetch_pkg;

    // BOOT  : first cycle after reset, nothing issued yet
    // READY : no request outstanding
    // WAIT  : request outstanding, its data is wanted
    // DRAIN : stale request outstanding, new target parked in pending
    // FAULT : misaligned redirect seen, fetch halted until reset
    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_READY = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

    // 32-bit instruction alignment: both low address bits must be zero.
    localparam logic [1:0]  IALIGN_MASK      = 2'b11;
    localparam int unsigned PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return |(addr_lsbs & IALIGN_MASK);
    endfunction

endpackage

// File: rtl/fetch_pc_sequencer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous active-low reset (count -> 0)
//     inc    in   add one this cycle (ignored once saturated)
//     count  out  current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_pc_sequencer
//   Owns the program counter and sequences instruction-memory fetches.
//   Applies EX-stage redirects, drains a request that was already in flight
//   when a redirect arrived, raises IF/ID and ID/EX flushes, and traps
//   misaligned redirect targets into a sticky fault state.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     stall              hazard unit: do not start a new fetch
//     redirect_valid     taken jump/branch from EX
//     redirect_addr      jump/branch target
//     imem_req/addr      fetch request (held until imem_ack), address = pc
//     imem_ack           memory completes the request this cycle
//     fetch_valid        imem data this cycle is a valid instruction
//     fetch_pc           PC of that instruction
//     flush_ifid/idex    kill IF/ID and ID/EX contents this cycle
//     misaligned_fault   sticky fault flag
//     fault_addr         offending redirect target
//     redirect_count     accepted redirects, saturating
// ---------------------------------------------------------------------------
module fetch_pc_sequencer
    import fetch_pkg::*;
#(
    parameter int                            ADDR_WIDTH_IN_BIT = 32,
    parameter logic [ADDR_WIDTH_IN_BIT-1:0]  RESET_PC          = DEFAULT_RESET_PC,
    parameter int                            CNT_WIDTH         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH_IN_BIT-1:0] redirect_addr,
    output logic                         imem_req,
    output logic [ADDR_WIDTH_IN_BIT-1:0] imem_addr,
    input  logic                         imem_ack,
    output logic                         fetch_valid,
    output logic [ADDR_WIDTH_IN_BIT-1:0] fetch_pc,
    output logic                         flush_ifid,
    output logic                         flush_idex,
    output logic                         misaligned_fault,
    output logic [ADDR_WIDTH_IN_BIT-1:0] fault_addr,
    output logic [CNT_WIDTH-1:0]         redirect_count
);

    localparam logic [ADDR_WIDTH_IN_BIT-1:0] PC_INC = ADDR_WIDTH_IN_BIT'(PC_STEP);

    fetch_state_e                 state_reg, state_next;
    logic [ADDR_WIDTH_IN_BIT-1:0] pc_reg, pc_next;
    logic [ADDR_WIDTH_IN_BIT-1:0] pending_reg, pending_next;
    logic [ADDR_WIDTH_IN_BIT-1:0] fault_addr_reg, fault_addr_next;
    logic                         flush;
    logic                         count_inc;
    logic                         redirect_bad;
    logic                         redirect_ok;

    assign redirect_bad = redirect_valid & is_misaligned(redirect_addr[1:0]);
    assign redirect_ok  = redirect_valid & ~redirect_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_BOOT;
            pc_reg         <= RESET_PC;
            pending_reg    <= '0;
            fault_addr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pending_reg    <= pending_next;
            fault_addr_reg <= fault_addr_next;
        end
    end

    // Within READY/WAIT/DRAIN the branches are ordered by priority:
    // misaligned redirect, then aligned redirect, then ack.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pending_next    = pending_reg;
        fault_addr_next = fault_addr_reg;
        imem_req        = 1'b0;
        fetch_valid     = 1'b0;
        flush           = 1'b0;
        count_inc       = 1'b0;

        case (state_reg)
            ST_BOOT: begin
                state_next = ST_READY;
            end

            ST_READY: begin
                // A redirect cycle never issues: the pc is about to change.
                imem_req = ~stall & ~redirect_valid;
                flush    = redirect_valid;
                if (redirect_bad) begin
                    state_next      = ST_FAULT;
                    fault_addr_next = redirect_addr;
                end else if (redirect_ok) begin
                    pc_next   = redirect_addr;
                    count_inc = 1'b1;
                end else if (imem_req && imem_ack) begin
                    fetch_valid = 1'b1;
                    pc_next     = pc_reg + PC_INC;
                end else if (imem_req) begin
                    state_next = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Once issued the request is held regardless of stall; the
                // IF/ID skid entry absorbs data returning during a stall.
                imem_req = 1'b1;
                flush    = redirect_valid;
                if (redirect_bad) begin
                    state_next      = ST_FAULT;
                    fault_addr_next = redirect_addr;
                end else if (redirect_ok) begin
                    count_inc = 1'b1;
                    if (imem_ack) begin
                        pc_next    = redirect_addr;
                        state_next = ST_READY;
                    end else begin
                        pending_next = redirect_addr;
                        state_next   = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    fetch_valid = 1'b1;
                    pc_next     = pc_reg + PC_INC;
                    state_next  = ST_READY;
                end
            end

            ST_DRAIN: begin
                // Old request must complete on the old address; its data is
                // thrown away. Latest redirect target wins.
                imem_req = 1'b1;
                flush    = redirect_valid;
                if (redirect_bad) begin
                    state_next      = ST_FAULT;
                    fault_addr_next = redirect_addr;
                end else if (redirect_ok) begin
                    count_inc = 1'b1;
                    if (imem_ack) begin
                        pc_next    = redirect_addr;
                        state_next = ST_READY;
                    end else begin
                        pending_next = redirect_addr;
                    end
                end else if (imem_ack) begin
                    pc_next    = pending_reg;
                    state_next = ST_READY;
                end
            end

            ST_FAULT: begin
                // Halted; any outstanding ack is ignored. Only reset exits.
            end

            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_redirect_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (count_inc),
        .count (redirect_count)
    );

    assign imem_addr        = pc_reg;
    assign fetch_pc         = pc_reg;
    assign flush_ifid       = flush;
    assign flush_idex       = flush;
    assign misaligned_fault = (state_reg == ST_FAULT);
    assign fault_addr       = fault_addr_reg;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_sequencer
//   Directed bench for fetch_pc_sequencer. A main instance (RESET_PC=0) is
//   checked every cycle against a transaction-level model and at key points
//   against hand-computed literals. A second instance (RESET_PC=0xFFFF_FFF8,
//   2-bit counter, ack tied high) covers PC wrap and counter saturation.
// ---------------------------------------------------------------------------
module tb_fetch_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        rv;
    logic [31:0] ra;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        fv;
    logic [31:0] fpc;
    logic        fl_ifid;
    logic        fl_idex;
    logic        fault;
    logic [31:0] faddr;
    logic [15:0] cnt;

    logic        w_rst_n;
    logic        w_stall;
    logic        w_rv;
    logic [31:0] w_ra;
    logic        w_ack;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_fv;
    logic [31:0] w_fpc;
    logic        w_fl_ifid;
    logic        w_fl_idex;
    logic        w_fault;
    logic [31:0] w_faddr;
    logic [1:0]  w_cnt;

    int n_cmp = 0;
    int n_err = 0;

    fetch_pc_sequencer u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .redirect_valid   (rv),
        .redirect_addr    (ra),
        .imem_req         (req),
        .imem_addr        (addr),
        .imem_ack         (ack),
        .fetch_valid      (fv),
        .fetch_pc         (fpc),
        .flush_ifid       (fl_ifid),
        .flush_idex       (fl_idex),
        .misaligned_fault (fault),
        .fault_addr       (faddr),
        .redirect_count   (cnt)
    );

    fetch_pc_sequencer #(
        .ADDR_WIDTH_IN_BIT (32),
        .RESET_PC          (32'hFFFF_FFF8),
        .CNT_WIDTH         (2)
    ) u_wrap (
        .clk              (clk),
        .rst_n            (w_rst_n),
        .stall            (w_stall),
        .redirect_valid   (w_rv),
        .redirect_addr    (w_ra),
        .imem_req         (w_req),
        .imem_addr        (w_addr),
        .imem_ack         (w_ack),
        .fetch_valid      (w_fv),
        .fetch_pc         (w_fpc),
        .flush_ifid       (w_fl_ifid),
        .flush_idex       (w_fl_idex),
        .misaligned_fault (w_fault),
        .fault_addr       (w_faddr),
        .redirect_count   (w_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Transaction-level model of the main instance. It tracks whether a
    // fetch is outstanding and whether its data is to be discarded, plus the
    // architectural pc, the parked target, fault info and redirect count.
    // -----------------------------------------------------------------------
    logic        m_boot  = 1'b1;
    logic        m_fault = 1'b0;
    logic        m_out   = 1'b0;
    logic        m_disc  = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_pend  = 32'h0;
    logic [31:0] m_faddr = 32'h0;
    int unsigned m_cnt   = 0;
    logic        e_req;
    logic        e_flush;
    logic        e_fv;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_boot  = 1'b1;
            m_fault = 1'b0;
            m_out   = 1'b0;
            m_disc  = 1'b0;
            m_pc    = 32'h0;
            m_pend  = 32'h0;
            m_faddr = 32'h0;
            m_cnt   = 0;
        end
        e_req   = !m_boot && !m_fault && (m_out || (!stall && !rv));
        e_flush = !m_boot && !m_fault && rv;
        e_fv    = e_req && ack && !m_disc && !rv;

        chk("cyc imem_req",    {31'd0, req},     {31'd0, e_req});
        chk("cyc imem_addr",   addr,             m_pc);
        chk("cyc fetch_pc",    fpc,              m_pc);
        chk("cyc fetch_valid", {31'd0, fv},      {31'd0, e_fv});
        chk("cyc flush_ifid",  {31'd0, fl_ifid}, {31'd0, e_flush});
        chk("cyc flush_idex",  {31'd0, fl_idex}, {31'd0, e_flush});
        chk("cyc fault",       {31'd0, fault},   {31'd0, m_fault});
        chk("cyc fault_addr",  faddr,            m_faddr);
        chk("cyc count",       {16'd0, cnt},     m_cnt);

        if (rst_n) begin
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_fault) begin
                // halted
            end else if (rv && (ra[1:0] != 2'b00)) begin
                m_fault = 1'b1;
                m_faddr = ra;
                m_out   = 1'b0;
                m_disc  = 1'b0;
            end else if (rv) begin
                if (m_cnt < 32'd65535) m_cnt++;
                if (m_out && !ack) begin
                    m_disc = 1'b1;
                    m_pend = ra;
                end else begin
                    m_pc   = ra;
                    m_out  = 1'b0;
                    m_disc = 1'b0;
                end
            end else if (e_req && ack) begin
                m_pc   = m_disc ? m_pend : m_pc + 32'd4;
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (e_req) begin
                m_out = 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One transaction per cycle: apply inputs just after the edge, let the
    // combinational outputs settle, leave the literal checks to the caller.
    task automatic drive(input logic s, input logic r, input logic [31:0] a, input logic k);
        cyc();
        stall = s;
        rv    = r;
        ra    = a;
        ack   = k;
        #2;
        $display("t=%0t stall=%b redirect=%b target=%08h ack=%b -> req=%b addr=%08h valid=%b flush=%b",
                 $time, s, r, a, k, req, addr, fv, fl_ifid);
    endtask

    initial begin
        rst_n   = 1'b0;
        stall   = 1'b0;
        rv      = 1'b0;
        ra      = 32'h0;
        ack     = 1'b0;
        w_rst_n = 1'b0;
        w_stall = 1'b0;
        w_rv    = 1'b0;
        w_ra    = 32'h0;
        w_ack   = 1'b1;

        #3;
        chk("rst req",   {31'd0, req},   32'd0);
        chk("rst addr",  addr,           32'h0);
        chk("rst count", {16'd0, cnt},   32'd0);
        chk("rst fault", {31'd0, fault}, 32'd0);
        cyc();

        // 1: free-running fetch after BOOT
        cyc();
        rst_n = 1'b1;
        ack   = 1'b1;
        #2;
        chk("t1 boot req", {31'd0, req}, 32'd0);
        drive(0, 0, 32'h0, 1);
        chk("t1 addr0", addr, 32'h0);
        chk("t1 valid0", {31'd0, fv}, 32'd1);
        drive(0, 0, 32'h0, 1);
        chk("t1 addr4", addr, 32'h4);
        drive(0, 0, 32'h0, 1);
        chk("t1 addr8", addr, 32'h8);

        // 2: ack delayed three cycles
        drive(0, 0, 32'h0, 0);
        chk("t2 addr c0", addr, 32'hC);
        drive(0, 0, 32'h0, 0);
        chk("t2 addr c1", addr, 32'hC);
        chk("t2 req c1", {31'd0, req}, 32'd1);
        drive(0, 0, 32'h0, 0);
        chk("t2 addr c2", addr, 32'hC);
        chk("t2 novalid", {31'd0, fv}, 32'd0);
        drive(0, 0, 32'h0, 1);
        chk("t2 valid", {31'd0, fv}, 32'd1);
        chk("t2 fetch_pc", fpc, 32'hC);

        // 3: redirect while waiting -> drain, stale data dropped
        drive(0, 0, 32'h0, 0);
        chk("t3 addr", addr, 32'h10);
        drive(0, 1, 32'h100, 0);
        chk("t3 flush_ifid", {31'd0, fl_ifid}, 32'd1);
        chk("t3 flush_idex", {31'd0, fl_idex}, 32'd1);
        drive(0, 0, 32'h0, 0);
        chk("t3 drain addr", addr, 32'h10);
        chk("t3 noflush", {31'd0, fl_ifid}, 32'd0);
        chk("t3 count", {16'd0, cnt}, 32'd1);
        drive(0, 0, 32'h0, 1);
        chk("t3 discard", {31'd0, fv}, 32'd0);
        drive(0, 0, 32'h0, 0);
        chk("t3 new addr", addr, 32'h100);

        // 4: redirect coincident with ack
        drive(0, 1, 32'h200, 1);
        chk("t4 valid", {31'd0, fv}, 32'd0);
        drive(0, 0, 32'h0, 1);
        chk("t4 addr", addr, 32'h200);
        chk("t4 valid next", {31'd0, fv}, 32'd1);
        chk("t4 count", {16'd0, cnt}, 32'd2);

        // stall handling, redirect from READY, double redirect in DRAIN
        drive(1, 0, 32'h0, 1);
        chk("st noreq", {31'd0, req}, 32'd0);
        drive(1, 1, 32'h300, 0);
        drive(0, 0, 32'h0, 1);
        chk("st addr", addr, 32'h300);
        drive(0, 0, 32'h0, 0);
        drive(1, 0, 32'h0, 1);
        chk("st held req", {31'd0, req}, 32'd1);
        chk("st held valid", {31'd0, fv}, 32'd1);
        chk("st held pc", fpc, 32'h304);
        drive(1, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 0);
        drive(0, 1, 32'h400, 0);
        drive(0, 1, 32'h500, 0);
        chk("dr old addr", addr, 32'h308);
        drive(0, 0, 32'h0, 1);
        drive(0, 0, 32'h0, 0);
        chk("dr latest wins", addr, 32'h500);
        chk("dr count", {16'd0, cnt}, 32'd5);

        // 5: misaligned redirect (coincident ack ignored), then reset
        drive(0, 1, 32'h102, 1);
        chk("t5 flush", {31'd0, fl_ifid}, 32'd1);
        chk("t5 valid", {31'd0, fv}, 32'd0);
        drive(0, 0, 32'h0, 1);
        chk("t5 fault", {31'd0, fault}, 32'd1);
        chk("t5 fault_addr", faddr, 32'h102);
        chk("t5 noreq", {31'd0, req}, 32'd0);
        chk("t5 pc", addr, 32'h500);
        drive(0, 1, 32'h600, 0);
        chk("t5 ignore flush", {31'd0, fl_ifid}, 32'd0);
        chk("t5 count", {16'd0, cnt}, 32'd5);
        cyc();
        rv    = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("t5 rst fault", {31'd0, fault}, 32'd0);
        chk("t5 rst addr", addr, 32'h0);
        chk("t5 rst fault_addr", faddr, 32'h0);
        cyc();
        rst_n = 1'b1;
        ack   = 1'b1;
        #2;
        drive(0, 0, 32'h0, 1);
        chk("t5 restart addr", addr, 32'h0);
        chk("t5 restart valid", {31'd0, fv}, 32'd1);

        // reset abandons an outstanding request
        drive(0, 0, 32'h0, 0);
        cyc();
        rst_n = 1'b0;
        #2;
        chk("mid rst req", {31'd0, req}, 32'd0);
        cyc();
        rst_n = 1'b1;
        #2;
        drive(0, 0, 32'h0, 1);
        chk("mid rst addr", addr, 32'h0);

        // 6: address wrap and stall on the second instance
        cyc();
        w_rst_n = 1'b1;
        #2;
        chk("t6 boot req", {31'd0, w_req}, 32'd0);
        chk("t6 boot addr", w_addr, 32'hFFFF_FFF8);
        cyc(); #2;
        chk("t6 addr a", w_addr, 32'hFFFF_FFF8);
        chk("t6 valid a", {31'd0, w_fv}, 32'd1);
        cyc(); #2;
        chk("t6 addr b", w_addr, 32'hFFFF_FFFC);
        cyc(); #2;
        chk("t6 addr wrap", w_addr, 32'h0);
        cyc();
        w_stall = 1'b1;
        #2;
        chk("t6 stall req", {31'd0, w_req}, 32'd0);
        chk("t6 stall valid", {31'd0, w_fv}, 32'd0);
        chk("t6 stall addr", w_addr, 32'h4);

        // counter saturation (2-bit): four redirects -> 3
        cyc();
        w_rv = 1'b1;
        w_ra = 32'h40;
        #2;
        chk("sat flush", {31'd0, w_fl_idex}, 32'd1);
        cyc(); w_ra = 32'h80; #2;
        chk("sat cnt1", {30'd0, w_cnt}, 32'd1);
        cyc(); w_ra = 32'hC0; #2;
        chk("sat cnt2", {30'd0, w_cnt}, 32'd2);
        cyc(); w_ra = 32'h100; #2;
        chk("sat cnt3", {30'd0, w_cnt}, 32'd3);
        cyc(); w_rv = 1'b0; #2;
        chk("sat hold", {30'd0, w_cnt}, 32'd3);
        chk("sat pc", w_addr, 32'h100);

        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
